// File: rtl/ftoi_wb_buffer.sv
// ============================================================================
// Module   : ftoi_wb_buffer
// Purpose  : Credit-issuing tag/result buffer between ftoi and RF writeback.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ftoi_wb_buffer #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [TAG_W-1:0]  iss_rd,
    output logic              iss_ready,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              wb_valid,
    output logic [TAG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    input  logic              wb_ready,
    output logic              err_orphan
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [TAG_W-1:0]  tq      [DEPTH];
    logic [TAG_W-1:0]  rq_tag  [DEPTH];
    logic [DATA_W-1:0] rq_data [DEPTH];

    logic [PW-1:0] tq_wr, tq_rd, rq_wr, rq_rd;
    logic [CW-1:0] cnt;

    logic tq_empty, rq_empty;
    logic issue_fire, res_take, wb_fire;

    assign tq_empty   = (tq_wr == tq_rd);
    assign rq_empty   = (rq_wr == rq_rd);
    assign iss_ready  = (cnt < CW'(DEPTH));
    assign issue_fire = iss_valid && iss_ready;
    assign res_take   = res_valid && !tq_empty;
    assign wb_valid   = !rq_empty;
    assign wb_fire    = wb_valid && wb_ready;

    // Array contents are never reset; the head is masked until it is valid.
    assign wb_rd   = wb_valid ? rq_tag[rq_rd[AW-1:0]]  : '0;
    assign wb_data = wb_valid ? rq_data[rq_rd[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (issue_fire) begin
            tq[tq_wr[AW-1:0]] <= iss_rd;
        end
        if (res_take) begin
            rq_tag[rq_wr[AW-1:0]]  <= tq[tq_rd[AW-1:0]];
            rq_data[rq_wr[AW-1:0]] <= res_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tq_wr      <= '0;
            tq_rd      <= '0;
            rq_wr      <= '0;
            rq_rd      <= '0;
            cnt        <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (issue_fire) begin
                tq_wr <= tq_wr + PW'(1);
            end
            if (res_take) begin
                tq_rd <= tq_rd + PW'(1);
                rq_wr <= rq_wr + PW'(1);
            end
            if (res_valid && tq_empty) begin
                err_orphan <= 1'b1;
            end
            if (wb_fire) begin
                rq_rd <= rq_rd + PW'(1);
            end
            // A result moves a credit from TQ to RQ, so only issue/writeback touch cnt.
            if (issue_fire && !wb_fire) begin
                cnt <= cnt + CW'(1);
            end else if (!issue_fire && wb_fire) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ftoi_wb_buffer.sv
// ============================================================================
// Module   : tb_ftoi_wb_buffer
// Purpose  : Scoreboard bench for ftoi_wb_buffer with a 3-stage ftoi model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ftoi_wb_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [5:0]  iss_rd;
    logic        iss_ready;
    logic        res_valid;
    logic [31:0] res_data;
    logic        wb_valid;
    logic [5:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        err_orphan;

    int compared   = 0;
    int mismatched = 0;

    logic [37:0] sb[$];

    logic        use_pipe;
    logic        man_v;
    logic [31:0] man_d;
    real         in_real;
    logic [2:0]  pv;
    logic [31:0] pd [3];

    always #5 clk = ~clk;

    ftoi_wb_buffer #(.DEPTH(4), .TAG_W(6), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .res_valid(res_valid), .res_data(res_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
        .err_orphan(err_orphan)
    );

    // Fixed-latency, non-stalling ftoi stand-in (truncation toward zero).
    always @(posedge clk) begin
        if (rst) begin
            pv <= '0;
        end else begin
            pv    <= {pv[1:0], iss_valid && iss_ready};
            pd[0] <= $rtoi(in_real);
            pd[1] <= pd[0];
            pd[2] <= pd[1];
        end
    end

    assign res_valid = use_pipe ? pv[2] : man_v;
    assign res_data  = use_pipe ? pd[2] : man_d;

    always @(negedge clk) begin
        if (!rst && wb_valid && wb_ready) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_wb: got rd=%0d data=%0d, required no writeback", wb_rd, $signed(wb_data));
            end else begin
                logic [37:0] e;
                e = sb.pop_front();
                if ({wb_rd, wb_data} !== e) begin
                    mismatched++;
                    $display("FAIL wb_entry: got rd=%0d data=%0d, required rd=%0d data=%0d",
                             wb_rd, $signed(wb_data), e[37:32], $signed(e[31:0]));
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic iss(input logic [5:0] tag, input int exp, input real fv);
        bit done = 0;
        iss_valid = 1'b1;
        iss_rd    = tag;
        in_real   = fv;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (iss_ready) begin
                sb.push_back({tag, exp[31:0]});
                done = 1;
            end
            step();
        end
        iss_valid = 1'b0;
        if (!done) chk("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic manual_res(input int d);
        man_v = 1'b1;
        man_d = d;
        step();
        man_v = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        iss_valid = 1'b0;
        wb_ready  = 1'b1;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && pv == 3'b000) done = 1;
            step();
        end
        if (!done) chk("drain_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("drained_wb_valid", {31'd0, wb_valid}, 32'd0);
        step();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        sb.delete();
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    task automatic run_random(input int n, inout int k);
        int issued = 0;
        int v;
        int e;
        real r;
        for (int c = 0; c < 40 * n && issued < n; c++) begin
            if (k == 0) begin
                r = 1591356.5; e = 1591356;
            end else if (k == 1) begin
                r = 2.5; e = 2;
            end else if (k == 2) begin
                r = -2.5; e = -2;
            end else begin
                v = int'($urandom_range(0, 2000000)) - 1000000;
                r = real'(v) / 8.0;
                e = v / 8;
            end
            wb_ready  = ($urandom_range(0, 3) != 0);
            iss_valid = ($urandom_range(0, 3) != 0);
            iss_rd    = 6'(k);
            in_real   = r;
            @(negedge clk);
            if (iss_valid && iss_ready) begin
                sb.push_back({6'(k), e[31:0]});
                k++;
                issued++;
            end
            step();
        end
        iss_valid = 1'b0;
        if (issued < n) chk("random_issue_timeout", 32'(issued), 32'(n));
    endtask

    initial begin
        int k;
        rst = 1'b1; iss_valid = 1'b0; iss_rd = '0; wb_ready = 1'b0;
        use_pipe = 1'b0; man_v = 1'b0; man_d = '0; in_real = 0.0;

        // Reset
        step();
        do_reset(3);
        @(negedge clk);
        chk("rst_iss_ready", {31'd0, iss_ready}, 32'd1);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_err_orphan", {31'd0, err_orphan}, 32'd0);
        chk("rst_wb_rd", {26'd0, wb_rd}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        step();

        // Single op and result-to-writeback latency
        wb_ready = 1'b1;
        iss(6'd5, 100, 0.0);
        step();
        man_v = 1'b1; man_d = 32'd100;
        @(negedge clk);
        chk("no_bypass", {31'd0, wb_valid}, 32'd0);
        step();
        man_v = 1'b0;
        @(negedge clk);
        chk("single_latency", {31'd0, wb_valid}, 32'd1);
        step();
        @(negedge clk);
        chk("single_after_pop", {31'd0, wb_valid}, 32'd0);
        step();

        // Backpressure
        wb_ready = 1'b0;
        iss(6'd1, -2, 0.0);
        iss(6'd2, 0, 0.0);
        iss(6'd3, 2, 0.0);
        iss(6'd4, 4, 0.0);
        iss_valid = 1'b1; iss_rd = 6'd9;
        @(negedge clk);
        chk("full_not_ready", {31'd0, iss_ready}, 32'd0);
        step();
        @(negedge clk);
        chk("full_held", {31'd0, iss_ready}, 32'd0);
        step();
        iss_valid = 1'b0;
        manual_res(-2); manual_res(0); manual_res(2); manual_res(4);
        @(negedge clk);
        chk("bp_buffered", {31'd0, wb_valid}, 32'd1);
        chk("bp_still_full", {31'd0, iss_ready}, 32'd0);
        step();
        wb_ready = 1'b1;
        @(negedge clk);
        chk("credit_not_yet", {31'd0, iss_ready}, 32'd0);
        step();
        @(negedge clk);
        chk("credit_returned", {31'd0, iss_ready}, 32'd1);
        step();
        drain();

        // Simultaneous issue + result + writeback at cnt=3
        wb_ready = 1'b0;
        iss(6'd10, 11, 0.0);
        iss(6'd11, 22, 0.0);
        iss(6'd12, 33, 0.0);
        manual_res(11);
        iss_valid = 1'b1; iss_rd = 6'd13;
        man_v = 1'b1; man_d = 32'd22;
        wb_ready = 1'b1;
        @(negedge clk);
        chk("cnt3_ready", {31'd0, iss_ready}, 32'd1);
        if (iss_ready) sb.push_back({6'd13, 32'd44});
        step();
        iss_valid = 1'b0; man_v = 1'b0; wb_ready = 1'b0;
        @(negedge clk);
        chk("cnt_kept3", {31'd0, iss_ready}, 32'd1);
        chk("sim_head_valid", {31'd0, wb_valid}, 32'd1);
        chk("sim_head_rd", {26'd0, wb_rd}, 32'd11);
        step();
        iss(6'd14, 55, 0.0);
        @(negedge clk);
        chk("cnt4_full", {31'd0, iss_ready}, 32'd0);
        step();
        manual_res(33); manual_res(44); manual_res(55);
        drain();

        // Orphan result
        manual_res(77);
        @(negedge clk);
        chk("orphan_set", {31'd0, err_orphan}, 32'd1);
        chk("orphan_no_wb", {31'd0, wb_valid}, 32'd0);
        step();
        repeat (3) step();
        @(negedge clk);
        chk("orphan_sticky", {31'd0, err_orphan}, 32'd1);
        chk("orphan_still_no_wb", {31'd0, wb_valid}, 32'd0);
        step();
        do_reset(1);
        @(negedge clk);
        chk("orphan_cleared", {31'd0, err_orphan}, 32'd0);
        step();

        // End to end through the ftoi model, with a mid-run reset
        use_pipe = 1'b1;
        k = 0;
        run_random(500, k);
        drain();
        wb_ready = 1'b0;
        iss(6'd20, 1, 1.5);
        iss(6'd21, 2, 2.5);
        iss(6'd22, 3, 3.5);
        repeat (5) step();
        @(negedge clk);
        chk("pre_rst_buffered", {31'd0, wb_valid}, 32'd1);
        chk("pre_rst_full_minus1", {31'd0, iss_ready}, 32'd1);
        step();
        do_reset(1);
        wb_ready = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {31'd0, iss_ready}, 32'd1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("midrst_no_stale_wb", {31'd0, wb_valid}, 32'd0);
        end
        step();
        run_random(503, k);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
